// File: rtl/fds_wave_synth.sv
//------------------------------------------------------------------------------
// fds_wave_synth
// Famicom Disk System wavetable sound channel: 64 x 6-bit wave RAM played by
// a 24-bit phase accumulator, volume envelope, master volume scaling and an
// optional frequency modulator (32-entry step table driving a signed counter).
//
// Optional feature macro: FDS_SYNTH_MOD_EN
//   defined   -> modulator, mod envelope and mod table are built
//   undefined -> pitch = freq, $4084-$4088 writes ignored, $4092 reads 8'h40
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst_n     in   1  synchronous active-low reset
//   tick      in   1  one-clk pulse per CPU cycle; audio timers advance on it
//   cpu_addr  in  16  CPU address
//   cpu_dat   in   8  CPU write data
//   cpu_we    in   1  one-clk write strobe
//   cpu_rd    in   1  CPU read cycle in progress (level)
//   snd_oe    out  1  module drives CPU read data (combinational)
//   snd_dout  out  8  CPU read data (combinational)
//   snd_vol   out 12  unsigned audio sample, registered on tick
//------------------------------------------------------------------------------
module fds_wave_synth (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dat,
  input  logic        cpu_we,
  input  logic        cpu_rd,
  output logic        snd_oe,
  output logic [7:0]  snd_dout,
  output logic [11:0] snd_vol
);

  // Envelope period in ticks: 8 * (speed + 1) * master (max 130560).
  function automatic logic [16:0] env_period(input logic [5:0] speed,
                                             input logic [7:0] master);
    logic [16:0] prod;
    prod = {10'd0, ({1'b0, speed} + 7'd1)} * {9'd0, master};
    return prod << 3;
  endfunction

  // One envelope step: up saturates at 32, down saturates at 0.
  function automatic logic [5:0] env_step(input logic [5:0] gain,
                                          input logic       dir);
    logic [5:0] nxt;
    if (dir) begin
      if (gain < 6'd32) nxt = gain + 6'd1;
      else              nxt = gain;
    end else begin
      if (gain != 6'd0) nxt = gain - 6'd1;
      else              nxt = gain;
    end
    return nxt;
  endfunction

  // Master volume multiplier M[mvol] = {32, 21, 16, 13}.
  function automatic logic [5:0] mvol_mult(input logic [1:0] mvol);
    logic [5:0] m;
    case (mvol)
      2'd0:    m = 6'd32;
      2'd1:    m = 6'd21;
      2'd2:    m = 6'd16;
      2'd3:    m = 6'd13;
      default: m = 6'd32;
    endcase
    return m;
  endfunction

  // Write strobe is suppressed while reset is asserted.
  logic wr_s;
  logic wave_sel_s;
  logic wr_4080_s, wr_4082_s, wr_4083_s, wr_4089_s, wr_408a_s;

  assign wr_s       = cpu_we & rst_n;
  assign wave_sel_s = (cpu_addr[15:6] == 10'b01_0000_0001);
  assign wr_4080_s  = wr_s & (cpu_addr == 16'h4080);
  assign wr_4082_s  = wr_s & (cpu_addr == 16'h4082);
  assign wr_4083_s  = wr_s & (cpu_addr == 16'h4083);
  assign wr_4089_s  = wr_s & (cpu_addr == 16'h4089);
  assign wr_408a_s  = wr_s & (cpu_addr == 16'h408A);

  logic        vol_dis_r, vol_dir_r;
  logic [5:0]  vol_speed_r;
  logic [11:0] freq_r;
  logic        halt_r, env_halt_r;
  logic        wr_en_r;
  logic [1:0]  mvol_r;
  logic [7:0]  env_master_r;

  logic [5:0]  wave_mem [0:63];
  logic [23:0] acc_r;
  logic [11:0] pitch_s;
  logic [5:0]  wave_rd_s;
  logic [5:0]  held_r;
  logic [5:0]  sample_s;
  logic [5:0]  vol_gain_r;
  logic [16:0] vol_timer_r;
  logic [16:0] vol_period_s;
  logic        env_frz_s;
  logic [5:0]  gain_clip_s;
  logic [15:0] mix_full_s;
  logic [7:0]  mod_rd_s;

  // Control registers shared by the default build.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vol_dis_r    <= 1'b0;
      vol_dir_r    <= 1'b0;
      vol_speed_r  <= 6'd0;
      freq_r       <= 12'd0;
      halt_r       <= 1'b0;
      env_halt_r   <= 1'b0;
      wr_en_r      <= 1'b0;
      mvol_r       <= 2'd0;
      env_master_r <= 8'd0;
    end else begin
      if (wr_4080_s) begin
        vol_dis_r   <= cpu_dat[7];
        vol_dir_r   <= cpu_dat[6];
        vol_speed_r <= cpu_dat[5:0];
      end
      if (wr_4082_s) freq_r[7:0] <= cpu_dat;
      if (wr_4083_s) begin
        halt_r       <= cpu_dat[7];
        env_halt_r   <= cpu_dat[6];
        freq_r[11:8] <= cpu_dat[3:0];
      end
      if (wr_4089_s) begin
        wr_en_r <= cpu_dat[7];
        mvol_r  <= cpu_dat[1:0];
      end
      if (wr_408a_s) env_master_r <= cpu_dat;
    end
  end

  // Wave RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wave_sel_s && wr_s && wr_en_r) begin
      wave_mem[cpu_addr[5:0]] <= cpu_dat[5:0];
    end
  end

  // Phase accumulator; a halt write with bit7 clears it ahead of any add.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= 24'd0;
    end else if (wr_4083_s && cpu_dat[7]) begin
      acc_r <= 24'd0;
    end else if (tick && !halt_r && !wr_en_r) begin
      acc_r <= acc_r + {12'd0, pitch_s};
    end
  end

  assign wave_rd_s = wave_mem[acc_r[23:18]];
  // While the RAM is open for writes, the output keeps the last sample.
  assign sample_s  = wr_en_r ? held_r : wave_rd_s;

  // Tracks the playing sample so it can be held once wr_en rises.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_r <= 6'd0;
    end else if (!wr_en_r) begin
      held_r <= wave_rd_s;
    end
  end

  assign env_frz_s    = env_halt_r | halt_r | (env_master_r == 8'd0);
  assign vol_period_s = env_period(vol_speed_r, env_master_r);

  // Volume envelope: direct load when disabled, otherwise timed stepping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vol_gain_r  <= 6'd0;
      vol_timer_r <= 17'd0;
    end else if (wr_4080_s) begin
      vol_timer_r <= 17'd0;
      if (cpu_dat[7]) vol_gain_r <= cpu_dat[5:0];
      else            vol_gain_r <= vol_gain_r;
    end else if (vol_dis_r) begin
      vol_gain_r  <= vol_speed_r;
      vol_timer_r <= vol_timer_r;
    end else if (tick && !env_frz_s) begin
      if (vol_timer_r + 17'd1 >= vol_period_s) begin
        vol_gain_r  <= env_step(vol_gain_r, vol_dir_r);
        vol_timer_r <= 17'd0;
      end else begin
        vol_timer_r <= vol_timer_r + 17'd1;
      end
    end
  end

`ifdef FDS_SYNTH_MOD_EN
  logic wr_4084_s, wr_4085_s, wr_4086_s, wr_4087_s, wr_4088_s;
  assign wr_4084_s = wr_s & (cpu_addr == 16'h4084);
  assign wr_4085_s = wr_s & (cpu_addr == 16'h4085);
  assign wr_4086_s = wr_s & (cpu_addr == 16'h4086);
  assign wr_4087_s = wr_s & (cpu_addr == 16'h4087);
  assign wr_4088_s = wr_s & (cpu_addr == 16'h4088);

  // Mod table step applied to the 7-bit two's complement counter.
  function automatic logic [6:0] mod_step(input logic [6:0] ctr,
                                          input logic [2:0] code);
    logic [6:0] r;
    case (code)
      3'd0:    r = ctr;
      3'd1:    r = ctr + 7'd1;
      3'd2:    r = ctr + 7'd2;
      3'd3:    r = ctr + 7'd4;
      3'd4:    r = 7'd0;
      3'd5:    r = ctr - 7'd4;
      3'd6:    r = ctr - 7'd2;
      3'd7:    r = ctr - 7'd1;
      default: r = ctr;
    endcase
    return r;
  endfunction

  logic        mod_dis_r, mod_dir_r;
  logic [5:0]  mod_speed_r;
  logic [11:0] mfreq_r;
  logic        mhalt_r;
  logic [2:0]  mod_tab [0:31];
  logic [15:0] mod_acc_r;
  logic [4:0]  ptr_r;
  logic [6:0]  mod_ctr_r;
  logic [5:0]  mod_gain_r;
  logic [16:0] mod_timer_r;
  logic [16:0] mod_period_s;
  logic [16:0] mod_sum_s;
  logic        mod_clr_s;
  logic        mod_carry_s;
  logic signed [13:0] mod_prod_s, mod_term_s, pitch_sum_s;

  // Modulator control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mod_dis_r   <= 1'b0;
      mod_dir_r   <= 1'b0;
      mod_speed_r <= 6'd0;
      mfreq_r     <= 12'd0;
      mhalt_r     <= 1'b0;
    end else begin
      if (wr_4084_s) begin
        mod_dis_r   <= cpu_dat[7];
        mod_dir_r   <= cpu_dat[6];
        mod_speed_r <= cpu_dat[5:0];
      end
      if (wr_4086_s) mfreq_r[7:0] <= cpu_dat;
      if (wr_4087_s) begin
        mhalt_r       <= cpu_dat[7];
        mfreq_r[11:8] <= cpu_dat[3:0];
      end
    end
  end

  // Mod table push port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_4088_s && mhalt_r) begin
      mod_tab[ptr_r] <= cpu_dat[2:0];
    end
  end

  assign mod_sum_s   = {1'b0, mod_acc_r} + {5'd0, mfreq_r};
  assign mod_clr_s   = wr_4087_s & cpu_dat[7];
  assign mod_carry_s = tick & ~mhalt_r & ~mod_clr_s & mod_sum_s[16];

  // Modulator accumulator, table pointer and signed counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mod_acc_r <= 16'd0;
      ptr_r     <= 5'd0;
      mod_ctr_r <= 7'd0;
    end else begin
      if (mod_clr_s) begin
        mod_acc_r <= 16'd0;
      end else if (tick && !mhalt_r) begin
        mod_acc_r <= mod_sum_s[15:0];
      end
      if ((wr_4088_s && mhalt_r) || mod_carry_s) begin
        ptr_r <= ptr_r + 5'd1;
      end
      // A direct counter load wins over a table step in the same cycle.
      if (wr_4085_s) begin
        mod_ctr_r <= cpu_dat[6:0];
      end else if (mod_carry_s) begin
        mod_ctr_r <= mod_step(mod_ctr_r, mod_tab[ptr_r]);
      end
    end
  end

  assign mod_period_s = env_period(mod_speed_r, env_master_r);

  // Modulation envelope, same behaviour as the volume envelope.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mod_gain_r  <= 6'd0;
      mod_timer_r <= 17'd0;
    end else if (wr_4084_s) begin
      mod_timer_r <= 17'd0;
      if (cpu_dat[7]) mod_gain_r <= cpu_dat[5:0];
      else            mod_gain_r <= mod_gain_r;
    end else if (mod_dis_r) begin
      mod_gain_r  <= mod_speed_r;
      mod_timer_r <= mod_timer_r;
    end else if (tick && !env_frz_s) begin
      if (mod_timer_r + 17'd1 >= mod_period_s) begin
        mod_gain_r  <= env_step(mod_gain_r, mod_dir_r);
        mod_timer_r <= 17'd0;
      end else begin
        mod_timer_r <= mod_timer_r + 17'd1;
      end
    end
  end

  // Pitch = freq + (mod_ctr * mod_gain) >>> 4, clamped to 12 bits unsigned.
  always_comb begin
    mod_prod_s  = $signed({{7{mod_ctr_r[6]}}, mod_ctr_r}) *
                  $signed({8'd0, mod_gain_r});
    mod_term_s  = mod_prod_s >>> 4;
    pitch_sum_s = $signed({2'b00, freq_r}) + mod_term_s;
    if (pitch_sum_s[13]) begin
      pitch_s = 12'd0;
    end else if (pitch_sum_s > 14'sd4095) begin
      pitch_s = 12'd4095;
    end else begin
      pitch_s = pitch_sum_s[11:0];
    end
  end

  assign mod_rd_s = {2'b01, mod_gain_r};
`else
  assign pitch_s  = freq_r;
  assign mod_rd_s = 8'h40;
`endif

  // Mixer: sample * min(gain, 32) * M[mvol], scaled down by 32 on output.
  always_comb begin
    if (vol_gain_r > 6'd32) gain_clip_s = 6'd32;
    else                    gain_clip_s = vol_gain_r;
    mix_full_s = {10'd0, sample_s} * {10'd0, gain_clip_s} *
                 {10'd0, mvol_mult(mvol_r)};
  end

  // Audio output register, updated once per tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snd_vol <= 12'd0;
    end else if (tick) begin
      snd_vol <= 12'(mix_full_s >> 5);
    end
  end

  // CPU read mux: wave RAM and the two gain readback ports.
  always_comb begin
    snd_oe   = 1'b0;
    snd_dout = 8'd0;
    if (cpu_rd && wave_sel_s) begin
      snd_oe   = 1'b1;
      snd_dout = {2'b00, wave_mem[cpu_addr[5:0]]};
    end else if (cpu_rd && (cpu_addr == 16'h4090)) begin
      snd_oe   = 1'b1;
      snd_dout = {2'b01, vol_gain_r};
    end else if (cpu_rd && (cpu_addr == 16'h4092)) begin
      snd_oe   = 1'b1;
      snd_dout = mod_rd_s;
    end else begin
      snd_oe   = 1'b0;
      snd_dout = 8'd0;
    end
  end

endmodule

// File: tb/tb_fds_wave_synth.sv
//------------------------------------------------------------------------------
// tb_fds_wave_synth
// Directed bench for fds_wave_synth: wave RAM access, playback ramp, master
// volume, sample hold, halt/clear, envelope stepping, reset behaviour and,
// when FDS_SYNTH_MOD_EN is defined, the modulator counter and pitch clamp.
//------------------------------------------------------------------------------
module tb_fds_wave_synth;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dat;
  logic        cpu_we;
  logic        cpu_rd;
  logic        snd_oe;
  logic [7:0]  snd_dout;
  logic [11:0] snd_vol;

  int total_cnt;
  int bad_cnt;

  logic [7:0] rd_d;
  logic       rd_oe;

  fds_wave_synth dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .cpu_addr (cpu_addr),
    .cpu_dat  (cpu_dat),
    .cpu_we   (cpu_we),
    .cpu_rd   (cpu_rd),
    .snd_oe   (snd_oe),
    .snd_dout (snd_dout),
    .snd_vol  (snd_vol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    if (got !== exp) begin
      bad_cnt = bad_cnt + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_dat  = d;
    cpu_we   = 1'b1;
    step();
    cpu_we   = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d,
                    output logic oe);
    cpu_addr = a;
    cpu_rd   = 1'b1;
    #2;
    d        = snd_dout;
    oe       = snd_oe;
    cpu_rd   = 1'b0;
    step();
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    tick      = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_dat   = 8'h00;
    cpu_we    = 1'b0;
    cpu_rd    = 1'b0;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    check_eq("rst_vol", {20'd0, snd_vol}, 32'd0);
    rd(16'h4090, rd_d, rd_oe);
    check_eq("rst_4090", {24'd0, rd_d}, 32'h40);
    check_eq("rst_4090_oe", {31'd0, rd_oe}, 32'd1);
    rd(16'h4091, rd_d, rd_oe);
    check_eq("unmapped_oe", {31'd0, rd_oe}, 32'd0);
`ifndef FDS_SYNTH_MOD_EN
    rd(16'h4092, rd_d, rd_oe);
    check_eq("nomod_4092", {24'd0, rd_d}, 32'h40);
    wr(16'h4084, 8'hA5);
    rd(16'h4092, rd_d, rd_oe);
    check_eq("nomod_4084_ign", {24'd0, rd_d}, 32'h40);
`endif

    // Fill wave RAM with a ramp
    wr(16'h4089, 8'h80);
    for (int i = 0; i < 64; i++) begin
      wr(16'h4040 + 16'(i), 8'(i));
    end
    rd(16'h4040, rd_d, rd_oe);
    check_eq("wave_first", {24'd0, rd_d}, 32'h00);
    rd(16'h407F, rd_d, rd_oe);
    check_eq("wave_last", {24'd0, rd_d}, 32'h3F);

    // Write with wr_en = 0 is ignored
    wr(16'h4089, 8'h00);
    wr(16'h4045, 8'h2A);
    rd(16'h4045, rd_d, rd_oe);
    check_eq("wave_wr_ign", {24'd0, rd_d}, 32'h05);
    check_eq("wave_rd_oe", {31'd0, rd_oe}, 32'd1);
    cpu_addr = 16'h4045;
    #2;
    check_eq("no_rd_oe", {31'd0, snd_oe}, 32'd0);
    step();

    // Playback ramp: gain 32, freq $400, one wave step per 256 ticks
    wr(16'h4080, 8'hA0);
    rd(16'h4090, rd_d, rd_oe);
    check_eq("gain_load", {24'd0, rd_d}, 32'h60);
    wr(16'h4082, 8'h00);
    wr(16'h4083, 8'h04);
    run_ticks(1);
    check_eq("ramp_k1", {20'd0, snd_vol}, 32'd0);
    run_ticks(256);
    check_eq("ramp_k257", {20'd0, snd_vol}, 32'd32);
    run_ticks(256);
    check_eq("ramp_k513", {20'd0, snd_vol}, 32'd64);
    wr(16'h4089, 8'h01);
    run_ticks(1);
    check_eq("mvol1", {20'd0, snd_vol}, 32'd42);
    wr(16'h4089, 8'h03);
    run_ticks(1);
    check_eq("mvol3", {20'd0, snd_vol}, 32'd26);
    wr(16'h4089, 8'h00);
    run_ticks(16384 - 515);
    check_eq("ramp_top", {20'd0, snd_vol}, 32'd2016);
    run_ticks(1);
    check_eq("ramp_wrap", {20'd0, snd_vol}, 32'd0);

    // Sample hold while wave RAM is writable
    run_ticks(1280);
    check_eq("pre_hold", {20'd0, snd_vol}, 32'd160);
    wr(16'h4089, 8'h80);
    wr(16'h4045, 8'h3F);
    run_ticks(1);
    check_eq("hold", {20'd0, snd_vol}, 32'd160);
    wr(16'h4089, 8'h00);
    run_ticks(1);
    check_eq("post_hold", {20'd0, snd_vol}, 32'd2016);

    // Halt write coincident with tick clears acc
    tick     = 1'b1;
    cpu_addr = 16'h4083;
    cpu_dat  = 8'h80;
    cpu_we   = 1'b1;
    step();
    tick   = 1'b0;
    cpu_we = 1'b0;
    step();
    check_eq("halt_acc", dut.acc_r, 32'd0);
    run_ticks(1);
    check_eq("halt_clear", {20'd0, snd_vol}, 32'd0);
    wr(16'h4083, 8'h84);
    run_ticks(300);
    check_eq("halt_hold", {20'd0, snd_vol}, 32'd0);
    wr(16'h4083, 8'h04);

    // Volume envelope: up at speed 1, master 1 -> step every 16 ticks
    wr(16'h408A, 8'h01);
    wr(16'h4080, 8'h80);
    rd(16'h4090, rd_d, rd_oe);
    check_eq("env_zero", {24'd0, rd_d}, 32'h40);
    wr(16'h4080, 8'h41);
    run_ticks(15);
    check_eq("env_t15", {24'd0, 2'b01, dut.vol_gain_r}, 32'h40);
    run_ticks(1);
    rd(16'h4090, rd_d, rd_oe);
    check_eq("env_t16", {24'd0, rd_d}, 32'h41);
    run_ticks(496);
    rd(16'h4090, rd_d, rd_oe);
    check_eq("env_32", {24'd0, rd_d}, 32'h60);
    run_ticks(100);
    rd(16'h4090, rd_d, rd_oe);
    check_eq("env_sat", {24'd0, rd_d}, 32'h60);
    wr(16'h4080, 8'h01);
    run_ticks(16);
    rd(16'h4090, rd_d, rd_oe);
    check_eq("env_down", {24'd0, rd_d}, 32'h5F);
    wr(16'h408A, 8'h00);
    run_ticks(50);
    rd(16'h4090, rd_d, rd_oe);
    check_eq("env_frozen", {24'd0, rd_d}, 32'h5F);
    check_eq("pre_rst_vol", {20'd0, snd_vol}, 32'd62);

    // One-cycle reset during output; a same-cycle write is ignored
    rst_n    = 1'b0;
    cpu_addr = 16'h4080;
    cpu_dat  = 8'hA0;
    cpu_we   = 1'b1;
    step();
    rst_n  = 1'b1;
    cpu_we = 1'b0;
    check_eq("rst2_vol", {20'd0, snd_vol}, 32'd0);
    check_eq("rst2_acc", dut.acc_r, 32'd0);
    rd(16'h4090, rd_d, rd_oe);
    check_eq("rst2_4090", {24'd0, rd_d}, 32'h40);
    rd(16'h4045, rd_d, rd_oe);
    check_eq("rst2_wave45", {24'd0, rd_d}, 32'h3F);
    rd(16'h4042, rd_d, rd_oe);
    check_eq("rst2_wave42", {24'd0, rd_d}, 32'h02);
    run_ticks(1);
    check_eq("rst2_tick", {20'd0, snd_vol}, 32'd0);

`ifdef FDS_SYNTH_MOD_EN
    // Modulator: table of +1 steps, gain 16, freq 100
    wr(16'h4087, 8'h80);
    for (int i = 0; i < 32; i++) begin
      wr(16'h4088, 8'h01);
    end
    wr(16'h4084, 8'h90);
    rd(16'h4092, rd_d, rd_oe);
    check_eq("mod_gain", {24'd0, rd_d}, 32'h50);
    wr(16'h4082, 8'h64);
    wr(16'h4083, 8'h80);
    wr(16'h4085, 8'h3F);
    check_eq("mod_p163", {20'd0, dut.pitch_s}, 32'd163);
    wr(16'h4086, 8'hFF);
    wr(16'h4087, 8'h0F);
    run_ticks(16);
    check_eq("mod_nocarry", {20'd0, dut.pitch_s}, 32'd163);
    run_ticks(1);
    check_eq("mod_wrap", {20'd0, dut.pitch_s}, 32'd36);
    wr(16'h4082, 8'h0A);
    check_eq("mod_clamp0", {20'd0, dut.pitch_s}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/fds_wave_synth.md
FDS_WAVE_SYNTH -- requirements
Module: fds_wave_synth

Interface
REQ-001 The module SHALL have port `clk`: input, 1 bit, system clock; all state updates on its rising edge.
REQ-002 The module SHALL have port `rst_n`: input, 1 bit, synchronous, active-low reset.
REQ-003 The module SHALL have port `tick`: input, 1 bit, single-`clk` pulse once per CPU cycle; all audio timers advance only on `tick`.
REQ-004 The module SHALL have port `cpu_addr`: input, 16 bits, CPU address.
REQ-005 The module SHALL have port `cpu_dat`: input, 8 bits, CPU write data.
REQ-006 The module SHALL have port `cpu_we`: input, 1 bit, single-`clk` write strobe; data is valid with it.
REQ-007 The module SHALL have port `cpu_rd`: input, 1 bit, level; CPU read cycle in progress.
REQ-008 The module SHALL have port `snd_oe`: output, 1 bit, module drives CPU read data.
REQ-009 The module SHALL have port `snd_dout`: output, 8 bits, CPU read data.
REQ-010 The module SHALL have port `snd_vol`: output, 12 bits, unsigned audio sample consumed by the FDS mapper mixer.

Function
REQ-011 Wave RAM SHALL be 64 x 6 bits; a write at $4040-$407F SHALL store `cpu_dat[5:0]` only while `wr_en` ($4089 bit7) = 1, and SHALL be ignored otherwise.
REQ-012 `snd_oe` SHALL equal `cpu_rd` & (addr in $4040-$407F | $4090 | $4092), combinationally.
REQ-013 `snd_dout` SHALL be {2'b00, wave[addr[5:0]]} for $404x-$407x, {2'b01, vol_gain} for $4090, and {2'b01, mod_gain} for $4092.
REQ-014 Register map: $4080 vol env {dis, dir, speed[5:0]}; $4082 freq[7:0]; $4083 {halt, env_halt, -, -, freq[11:8]}; $4084 mod env (same format as $4080); $4085 mod_ctr[6:0] (signed); $4086 mfreq[7:0]; $4087 {mhalt, ---, mfreq[11:8]}; $4088 mod table push; $4089 {wr_en, -----, mvol[1:0]}; $408A env_master[7:0].
REQ-015 Phase accumulator SHALL be 24 bits, adding `pitch` each `tick` unless halt | wr_en; wave index SHALL be acc[23:18].
REQ-016 Writing $4083 with bit7 = 1 SHALL clear acc in that cycle, overriding any same-cycle add.
REQ-017 Envelope units (vol, mod) SHALL have these behaviours:
- When dis = 1, gain SHALL be set to speed and the timer held.
- When dis = 0, the timer SHALL count `tick`s up to 8*(speed+1)*env_master.
- On expiry, gain SHALL step +1 (dir = 1, saturating at 32) or -1 (dir = 0, saturating at 0), and the timer SHALL reload.
- While env_halt = 1, halt = 1 or env_master = 0, the envelope clock SHALL be frozen.
REQ-018 A write to $4080 or $4084 SHALL reset that envelope's timer, and with dis = 1 SHALL load gain immediately; gain range SHALL be 0-63.
REQ-019 Modulator accumulator SHALL be 16 bits, adding mfreq each `tick` unless mhalt.
REQ-020 On carry out of the modulator accumulator, the mod table entry at ptr SHALL be applied to mod_ctr, then ptr SHALL advance (mod 32).
REQ-021 Mod table step values SHALL be: 0: +0, 1: +1, 2: +2, 3: +4, 4: set 0, 5: -4, 6: -2, 7: -1; mod_ctr SHALL wrap in 7-bit two's complement.
REQ-022 A $4088 write SHALL be accepted only while mhalt = 1; it SHALL store `cpu_dat[2:0]` at ptr and advance ptr by 1, wrapping 31 -> 0.
REQ-023 A $4087 write with bit7 = 1 SHALL clear the modulator accumulator.
REQ-024 A $4085 write SHALL load mod_ctr and win over a same-cycle table step; ptr SHALL be unchanged.
REQ-025 pitch SHALL equal freq + ((mod_ctr * mod_gain) >>> 4), computed with a signed 14-bit intermediate and clamped to 0..4095.
REQ-026 On each `tick`, `snd_vol` SHALL register (sample * min(vol_gain, 32) * M[mvol]) >> 5, with M = {32, 21, 16, 13}; the result is at most 2016, so no overflow.
REQ-027 While wr_en = 1, sample SHALL hold the last value output before wr_en was set.
REQ-028 Output latency SHALL be 1 `clk` after a `tick` for every register and state change.

Reset
REQ-029 While `rst_n` = 0 at a `clk` edge, all registers, both accumulators, both gains, ptr, envelope timers and `snd_vol` SHALL go to 0; `cpu_we` SHALL be ignored in that cycle.
REQ-030 Wave RAM and mod table contents SHALL NOT be cleared by reset.
REQ-031 When reset asserts mid-envelope or mid-sweep, the block SHALL restart cleanly with no residual output on the next `tick`.

Configuration
REQ-032 With `FDS_SYNTH_MOD_EN` defined, the modulator (REQ-019..025) SHALL be built.
REQ-033 Without `FDS_SYNTH_MOD_EN`:
- pitch SHALL equal freq.
- Writes to $4084-$4088 SHALL be ignored.
- $4092 SHALL read 8'h40.
- The mod table and modulator logic SHALL be absent.

Verification
REQ-034 Write $4089 = $80, wave[i] = i (i = 0..63), then $4089 = $00, $4080 = $A0 (gain 32), freq = $400, mvol = 0, mod off -> `snd_vol` ramps 0..2016 in 64 steps, one step every 256 ticks.
REQ-035 Wave RAM write with wr_en = 0 at $4045 -> a read of $4045 returns the previous value and `snd_oe` = 1.
REQ-036 $408A = 1, $4080 = $41 (up, speed 1) from gain 0 -> gain increments every 16 ticks, reaches 32 and saturates; $4090 reads $60.
REQ-037 Modulator (macro on): table all 1s, mfreq = $FFF, mod gain 16, freq = 100 -> mod_ctr +1 per carry, wrapping 63 -> -64; pitch clamps at 0 when the product goes negative past freq.
REQ-038 `rst_n` low for 1 clk during active output -> next cycle `snd_vol` = 0, acc = 0 and $4090 reads $40, while wave RAM is preserved.
REQ-039 A $4083 = $80 write coincident with a `tick` -> acc = 0 after the edge, and the sample is held while halted.
